trisc_datapath: RTL and testbench

TRISC_DATAPATH -- requirements
Module: trisc_datapath

---
 rtl/trisc_datapath_pkg.sv | 27 ++
 rtl/trisc_datapath_if.sv | 27 ++
 rtl/trisc_datapath_alu.sv | 34 +++
 rtl/trisc_datapath.sv | 96 +++++++++
 tb/tb_trisc_datapath.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/trisc_datapath_pkg.sv
// Shared widths, opcode and ALU operation encodings for the TRISC datapath.
package trisc_datapath_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'h0,
        OP_INC  = 4'h1,
        OP_CLR  = 4'h2,
        OP_JMP  = 4'h3,
        OP_LDA  = 4'h4,
        OP_STA  = 4'h5,
        OP_ADD  = 4'h6
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/trisc_datapath_if.sv
// Controller <-> datapath bundle: C-lines, program-load port, decoded flags and visible state.
interface trisc_datapath_if;
    import trisc_datapath_pkg::*;

    logic  C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14;
    logic  LoadEn;
    addr_t LoadAddr;
    data_t LoadData;
    logic  INC, CLR, JMP, LDA, STA, ADD;
    addr_t PC;
    data_t ACC;
    data_t MDO;
    logic  Carry;

    modport master (
        output C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14,
        output LoadEn, LoadAddr, LoadData,
        input  INC, CLR, JMP, LDA, STA, ADD, PC, ACC, MDO, Carry
    );

    modport slave (
        input  C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14,
        input  LoadEn, LoadAddr, LoadData,
        output INC, CLR, JMP, LDA, STA, ADD, PC, ACC, MDO, Carry
    );

endinterface

// File: rtl/trisc_datapath_alu.sv
// Combinational ALU: op(ACC, MDO) with carry-out for ADD and borrow for SUB.
module trisc_alu
    import trisc_datapath_pkg::*;
(
    input  data_t   ACC,
    input  data_t   MDO,
    input  alu_op_e op,
    output data_t   result,
    output logic    carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = '0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, ACC} + {1'b0, MDO};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = ACC - MDO;
                carry  = (ACC < MDO);
            end
            ALU_AND: result = ACC & MDO;
            ALU_OR:  result = ACC | MDO;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/trisc_datapath.sv
// TRISC datapath: PC, IR, MAR, MDO, ACC, ALUBuf, Carry and a 16x8 internal memory.
module trisc_datapath
    import trisc_datapath_pkg::*;
(
    input  logic SysClock,
    input  logic Reset,
    trisc_datapath_if.slave bus
);

    data_t   mem [16];
    addr_t   pc, mar;
    logic [3:0] ir;
    data_t   mdo, acc, alubuf;
    logic    carry;
    data_t   alu_result;
    logic    alu_carry;
    alu_op_e alu_op;

    assign alu_op = alu_op_e'({bus.C12, bus.C13});

    trisc_alu u_alu (
        .ACC    (acc),
        .MDO    (mdo),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Memory is never cleared; reset only blocks a write that lands on a reset edge.
    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset) begin
            pc     <= '0;
            ir     <= '0;
            mar    <= '0;
            mdo    <= '0;
            acc    <= '0;
            alubuf <= '0;
            carry  <= 1'b0;
        end else begin
            if (bus.LoadEn)
                mem[bus.LoadAddr] <= bus.LoadData;
            else if (bus.C5)
                mem[mar] <= acc;

            if (bus.C0)      pc <= '0;
            else if (bus.C1) pc <= mdo[ADDR_W-1:0];
            else if (bus.C2) pc <= pc + 1'b1;

            if (bus.C0)      ir <= '0;
            else if (bus.C7) ir <= mdo[DATA_W-1:DATA_W-4];

            if (bus.C0)      mar <= '0;
            else if (bus.C4) mar <= bus.C3 ? pc : mdo[ADDR_W-1:0];

            if (bus.C0) mdo <= '0;
            else        mdo <= mem[mar];

            if (bus.C0)       acc <= '0;
            else if (bus.C8)  acc <= '0;
            else if (bus.C11) acc <= bus.C10 ? mdo : alubuf;
            else if (bus.C9)  acc <= acc + 1'b1;

            if (bus.C0) begin
                alubuf <= '0;
                carry  <= 1'b0;
            end else if (bus.C14) begin
                alubuf <= alu_result;
                carry  <= alu_carry;
            end
        end
    end

    always_comb begin
        bus.INC = 1'b0;
        bus.CLR = 1'b0;
        bus.JMP = 1'b0;
        bus.LDA = 1'b0;
        bus.STA = 1'b0;
        bus.ADD = 1'b0;
        case (ir)
            OP_INC:  bus.INC = 1'b1;
            OP_CLR:  bus.CLR = 1'b1;
            OP_JMP:  bus.JMP = 1'b1;
            OP_LDA:  bus.LDA = 1'b1;
            OP_STA:  bus.STA = 1'b1;
            OP_ADD:  bus.ADD = 1'b1;
            default: ;
        endcase
    end

    assign bus.PC    = pc;
    assign bus.ACC   = acc;
    assign bus.MDO   = mdo;
    assign bus.Carry = carry;

endmodule

// File: tb/tb_trisc_datapath.sv
// Directed bench for trisc_datapath: opcode decode table plus hand-computed control sequences.
module tb_trisc_datapath;
    import trisc_datapath_pkg::*;

    logic SysClock = 1'b0;
    logic Reset    = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    trisc_datapath_if bus ();

    trisc_datapath dut (
        .SysClock (SysClock),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 SysClock = ~SysClock;

    localparam logic [15:0] K0  = 16'h0001, K1  = 16'h0002, K2  = 16'h0004, K3  = 16'h0008;
    localparam logic [15:0] K4  = 16'h0010, K5  = 16'h0020, K7  = 16'h0080, K8  = 16'h0100;
    localparam logic [15:0] K9  = 16'h0200, K10 = 16'h0400, K11 = 16'h0800, K12 = 16'h1000;
    localparam logic [15:0] K13 = 16'h2000, K14 = 16'h4000;

    typedef struct {
        logic [3:0] ir;
        logic [5:0] flags;   // {INC,CLR,JMP,LDA,STA,ADD}
    } dec_vec_t;

    dec_vec_t dec_tab [16];

    function automatic logic [5:0] flags();
        return {bus.INC, bus.CLR, bus.JMP, bus.LDA, bus.STA, bus.ADD};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] c, input logic le, input logic [3:0] la, input logic [7:0] ld);
        bus.C0  = c[0];  bus.C1  = c[1];  bus.C2  = c[2];  bus.C3  = c[3];
        bus.C4  = c[4];  bus.C5  = c[5];  bus.C7  = c[7];  bus.C8  = c[8];
        bus.C9  = c[9];  bus.C10 = c[10]; bus.C11 = c[11]; bus.C12 = c[12];
        bus.C13 = c[13]; bus.C14 = c[14];
        bus.LoadEn = le; bus.LoadAddr = la; bus.LoadData = ld;
    endtask

    task automatic step(input logic [15:0] c, input logic le = 1'b0,
                        input logic [3:0] la = 4'h0, input logic [7:0] ld = 8'h00);
        @(negedge SysClock);
        drive(c, le, la, ld);
        @(posedge SysClock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        step(16'h0, 1'b1, a, d);
    endtask

    task automatic fetch();
        step(K3); step(K3 | K4); step(K3 | K4); step(K2 | K7);
    endtask

    task automatic lda_operand();
        step(K4); step(K4); step(K10 | K11);
    endtask

    task automatic add_operand(input logic [15:0] op);
        step(K4); step(K4); step(K14 | op); step(16'h0); step(K11);
    endtask

    // Clears the datapath, walks PC to addr, points MAR at it and reads it back.
    task automatic read_mem(input logic [3:0] addr, output logic [7:0] d);
        step(K0);
        repeat (int'(addr)) step(K2);
        step(K3 | K4);
        step(16'h0);
        d = bus.MDO;
    endtask

    logic [7:0] rd;

    initial begin
        dec_tab = '{
            '{4'h0, 6'b000000}, '{4'h1, 6'b100000}, '{4'h2, 6'b010000}, '{4'h3, 6'b001000},
            '{4'h4, 6'b000100}, '{4'h5, 6'b000010}, '{4'h6, 6'b000001}, '{4'h7, 6'b000000},
            '{4'h8, 6'b000000}, '{4'h9, 6'b000000}, '{4'hA, 6'b000000}, '{4'hB, 6'b000000},
            '{4'hC, 6'b000000}, '{4'hD, 6'b000000}, '{4'hE, 6'b000000}, '{4'hF, 6'b000000}
        };
        drive(16'h0, 1'b0, 4'h0, 8'h00);

        #2 Reset = 1'b1;
        #1;
        chk("reset_pc", {4'h0, bus.PC}, 8'h00);
        chk("reset_acc", bus.ACC, 8'h00);
        chk("reset_mdo", bus.MDO, 8'h00);
        chk("reset_carry", {7'h0, bus.Carry}, 8'h00);
        chk("reset_flags", {2'b00, flags()}, 8'h00);
        @(negedge SysClock);
        Reset = 1'b0;

        // Program: LDA 5; LDA 8; ADD 6; LDA 8; ADD 9
        load(4'h0, 8'h45); load(4'h5, 8'h2A);
        load(4'h1, 8'h48); load(4'h8, 8'hF0);
        load(4'h2, 8'h66); load(4'h6, 8'h20);
        load(4'h3, 8'h48); load(4'h4, 8'h69); load(4'h9, 8'hF1);

        fetch();
        chk("fetch0_pc", {4'h0, bus.PC}, 8'h01);
        chk("fetch0_lda", {2'b00, flags()}, 8'h04);
        lda_operand();
        chk("lda_acc", bus.ACC, 8'h2A);

        fetch(); lda_operand();
        chk("lda2_acc", bus.ACC, 8'hF0);
        fetch();
        chk("fetch_add_flag", {2'b00, flags()}, 8'h01);
        chk("fetch_add_pc", {4'h0, bus.PC}, 8'h03);
        add_operand(16'h0);
        chk("add_acc", bus.ACC, 8'h10);
        chk("add_carry", {7'h0, bus.Carry}, 8'h01);

        fetch(); lda_operand();
        fetch(); add_operand(K13);
        chk("sub_acc", bus.ACC, 8'hFF);
        chk("sub_borrow", {7'h0, bus.Carry}, 8'h01);
        step(K14 | K12);
        chk("and_carry", {7'h0, bus.Carry}, 8'h00);
        step(K11);
        chk("and_acc", bus.ACC, 8'hF1);

        // Opcode decode table, IR loaded from the upper nibble of mem[14]
        step(K0);
        repeat (14) step(K2);
        step(K3 | K4);
        for (int i = 0; i < 16; i++) begin
            load(4'hE, {dec_tab[i].ir, 4'h0});
            step(16'h0);
            step(K7);
            chk($sformatf("decode_ir_%h", dec_tab[i].ir), {2'b00, flags()}, {2'b00, dec_tab[i].flags});
        end

        load(4'hE, 8'h3C);
        step(16'h0);
        chk("mdo_3c", bus.MDO, 8'h3C);
        step(K1 | K2);
        chk("jump_over_inc", {4'h0, bus.PC}, 8'h0C);
        step(K0 | K1);
        chk("clear_over_jump", {4'h0, bus.PC}, 8'h00);

        // PC and ACC wrap, ACC priority
        load(4'hF, 8'hFF);
        step(K0);
        repeat (15) step(K2);
        chk("pc_15", {4'h0, bus.PC}, 8'h0F);
        step(K2);
        chk("pc_wrap", {4'h0, bus.PC}, 8'h00);
        step(K0);
        repeat (15) step(K2);
        step(K3 | K4); step(16'h0); step(K10 | K11);
        chk("acc_ff", bus.ACC, 8'hFF);
        step(K9);
        chk("acc_wrap", bus.ACC, 8'h00);
        step(K9);
        chk("acc_inc", bus.ACC, 8'h01);
        step(K10 | K11 | K9);
        chk("load_over_inc", bus.ACC, 8'hFF);
        step(K8 | K11 | K9);
        chk("clear_over_load", bus.ACC, 8'h00);

        // Store with simultaneous MAR reload: write must hit the old MAR
        load(4'hA, 8'h5A); load(4'hC, 8'h17); load(4'h7, 8'h11); load(4'h3, 8'h27);
        step(K0);
        repeat (10) step(K2);
        step(K3 | K4); step(16'h0); step(K10 | K11);
        repeat (2) step(K2);
        step(K3 | K4); step(16'h0); step(K4);
        repeat (7) step(K2);
        chk("sta_pc", {4'h0, bus.PC}, 8'h03);
        step(K5 | K4 | K3);
        chk("sta_rbw_old", bus.MDO, 8'h11);
        step(16'h0);
        chk("sta_not_pc_addr", bus.MDO, 8'h27);
        step(K4); step(16'h0);
        chk("sta_new", bus.MDO, 8'h5A);
        step(K5, 1'b1, 4'h7, 8'h99);
        step(16'h0);
        chk("load_over_sta", bus.MDO, 8'h99);

        // Reset in the middle of an ADD
        load(4'hD, 8'h33);
        step(K0);
        repeat (13) step(K2);
        step(K3 | K4); step(16'h0); step(K7 | K10 | K11);
        chk("pre_rst_acc", bus.ACC, 8'h33);
        chk("pre_rst_jmp", {2'b00, flags()}, 8'h08);
        repeat (11) step(K2);
        step(K3 | K4); step(16'h0); step(K14);
        chk("pre_rst_carry", {7'h0, bus.Carry}, 8'h01);
        @(negedge SysClock);
        Reset = 1'b1;
        #1;
        chk("rst_pc", {4'h0, bus.PC}, 8'h00);
        chk("rst_acc", bus.ACC, 8'h00);
        chk("rst_mdo", bus.MDO, 8'h00);
        chk("rst_carry", {7'h0, bus.Carry}, 8'h00);
        chk("rst_flags", {2'b00, flags()}, 8'h00);
        drive(K5, 1'b1, 4'h8, 8'hEE);
        @(posedge SysClock);
        #1;
        @(negedge SysClock);
        Reset = 1'b0;
        drive(16'h0, 1'b0, 4'h0, 8'h00);
        step(16'h0);
        chk("post_rst_first_edge", bus.MDO, 8'h45);
        read_mem(4'h8, rd);
        chk("rst_write_discarded", rd, 8'hF0);
        read_mem(4'hD, rd);
        chk("rst_mem_kept_d", rd, 8'h33);
        read_mem(4'h5, rd);
        chk("rst_mem_kept_5", rd, 8'h2A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
